// File: rtl/mem_read_seq_if.sv
// rtl/mem_read_seq_if.sv - controller/sequencer bundle for the operand read-address sequencer
interface mem_read_seq_if #(
    parameter int N      = 3,
    parameter int ADDR_W = 4
);
    logic                         start;
    logic                         col_major;
    logic [ADDR_W-1:0]            base_addr;
    logic                         stall;
    logic [N-1:0][ADDR_W-1:0]     rd_addr_bram;
    logic [N-1:0]                 rd_en_bram;
    logic                         busy;
    logic                         done;

    modport master (
        output start, col_major, base_addr, stall,
        input  rd_addr_bram, rd_en_bram, busy, done
    );

    modport slave (
        input  start, col_major, base_addr, stall,
        output rd_addr_bram, rd_en_bram, busy, done
    );
endinterface

// File: rtl/mem_read_seq.sv
// rtl/mem_read_seq.sv - autonomous skewed read-address sequencer for one operand matrix
module mem_read_seq #(
    parameter int N = 3,
    parameter int M = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_read_seq_if.slave  bus
);
    localparam int R      = M / N;
    localparam int DEPTH  = (M * M) / N;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W  = (R > 1) ? $clog2(R) : 1;
    localparam int COL_W  = (M > 1) ? $clog2(M) : 1;
    localparam int DRN_W  = (N > 1) ? $clog2(N) : 1;
    // Wide enough for row*M+col and col*R+row with no overflow.
    localparam int OFF_W  = $clog2(M * M) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                     state;
    logic [ROW_W-1:0]           row;
    logic [COL_W-1:0]           col;
    logic [DRN_W-1:0]           drain;
    logic                       lat_cm;
    logic [ADDR_W-1:0]          lat_base;
    logic [N-1:0][ADDR_W-1:0]   lane_addr;
    logic [N-1:0]               lane_en;
    logic                       busy_r;
    logic                       done_r;

    logic                       is_last;
    logic [ROW_W-1:0]           nxt_row;
    logic [COL_W-1:0]           nxt_col;
    logic [OFF_W-1:0]           nxt_off;
    logic [ADDR_W-1:0]          nxt_addr;

    // Next (row, col) position and its bank address; the sum wraps modulo 2^ADDR_W.
    always_comb begin
        is_last = (row == ROW_W'(R - 1)) && (col == COL_W'(M - 1));
        nxt_row = row;
        nxt_col = col + COL_W'(1);
        if (col == COL_W'(M - 1)) begin
            nxt_col = '0;
            nxt_row = row + ROW_W'(1);
        end
        if (lat_cm) begin
            nxt_off = OFF_W'(nxt_col) * OFF_W'(R) + OFF_W'(nxt_row);
        end else begin
            nxt_off = OFF_W'(nxt_row) * OFF_W'(M) + OFF_W'(nxt_col);
        end
        nxt_addr = lat_base + nxt_off[ADDR_W-1:0];
    end

    // FSM, counters, live lane 0 and the skew chain; stall freezes all of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            drain     <= '0;
            lat_cm    <= 1'b0;
            lat_base  <= '0;
            lane_addr <= '0;
            lane_en   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (!bus.stall) begin
            for (int k = N - 1; k >= 1; k--) begin
                lane_addr[k] <= lane_addr[k-1];
                lane_en[k]   <= lane_en[k-1];
            end
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        lat_cm       <= bus.col_major;
                        lat_base     <= bus.base_addr;
                        row          <= '0;
                        col          <= '0;
                        // Offset of (0,0) is zero in both modes.
                        lane_addr[0] <= bus.base_addr;
                        lane_en[0]   <= 1'b1;
                        busy_r       <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_last) begin
                        lane_en[0] <= 1'b0;
                        if (N > 1) begin
                            drain <= DRN_W'(N - 1);
                            state <= S_DRAIN;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end else begin
                        row          <= nxt_row;
                        col          <= nxt_col;
                        lane_addr[0] <= nxt_addr;
                    end
                end
                S_DRAIN: begin
                    // Last decrement coincides with lane N-1 presenting its final enable.
                    if (drain == DRN_W'(1)) begin
                        drain  <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        drain <= drain - DRN_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_addr_bram = lane_addr;
    assign bus.rd_en_bram   = lane_en;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_mem_read_seq.sv
// tb/tb_mem_read_seq.sv - directed self-checking bench for mem_read_seq
module tb_mem_read_seq;
    localparam int N  = 3;
    localparam int RM = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_read_seq_if #(.N(3), .ADDR_W(4)) bus3 ();
    mem_read_seq_if #(.N(1), .ADDR_W(2)) bus1 ();

    mem_read_seq #(.N(3), .M(6)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
    mem_read_seq #(.N(1), .M(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_seq [12];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pass on the N=3 DUT; cycle c is checked, then its inputs are driven and the edge taken.
    task automatic run_pass(input string tag, input logic cm, input logic [3:0] base,
                            input int st_lo, input int st_hi, input int first,
                            input bit restart, input int abort_at, input int mid_start);
        int nstall, done_cyc, last, stalled, e;
        logic en_e;
        nstall   = (st_hi >= st_lo) ? (st_hi - st_lo + 1) : 0;
        done_cyc = RM + N + nstall;
        last     = restart ? done_cyc : done_cyc + 2;
        if (abort_at > 0) last = abort_at + 1;
        stalled = 0;
        for (int c = first; c <= last; c++) begin
            e = c - stalled;
            if (abort_at > 0 && c == abort_at + 1) begin
                for (int k = 0; k < N; k++) begin
                    check_eq($sformatf("%s c%0d rst lane%0d en", tag, c, k), 32'(bus3.rd_en_bram[k]), 0);
                    check_eq($sformatf("%s c%0d rst lane%0d addr", tag, c, k), 32'(bus3.rd_addr_bram[k]), 0);
                end
                check_eq($sformatf("%s c%0d rst busy", tag, c), 32'(bus3.busy), 0);
                check_eq($sformatf("%s c%0d rst done", tag, c), 32'(bus3.done), 0);
            end else begin
                for (int k = 0; k < N; k++) begin
                    en_e = (e >= 1 + k) && (e <= RM + k);
                    check_eq($sformatf("%s c%0d lane%0d en", tag, c, k), 32'(bus3.rd_en_bram[k]), 32'(en_e));
                    if (en_e)
                        check_eq($sformatf("%s c%0d lane%0d addr", tag, c, k),
                                 32'(bus3.rd_addr_bram[k]), 32'(exp_seq[e-1-k]));
                end
                check_eq($sformatf("%s c%0d busy", tag, c), 32'(bus3.busy), 32'((e >= 1) && (e <= RM + N - 1)));
                check_eq($sformatf("%s c%0d done", tag, c), 32'(bus3.done), 32'(e == RM + N));
            end
            bus3.start     = ((c == 0) && (first == 0)) || (restart && c == done_cyc) || (c == mid_start);
            bus3.col_major = (c == mid_start) ? ~cm : cm;
            bus3.base_addr = (c == mid_start) ? base + 4'd3 : base;
            bus3.stall     = (c >= st_lo) && (c <= st_hi);
            rst_n          = !(abort_at > 0 && c == abort_at);
            if (bus3.stall) stalled++;
            step();
        end
        bus3.start = 1'b0;
        bus3.stall = 1'b0;
        rst_n      = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus3.start     = 1'b0;
        bus3.col_major = 1'b0;
        bus3.base_addr = '0;
        bus3.stall     = 1'b0;
        bus1.start     = 1'b0;
        bus1.col_major = 1'b0;
        bus1.base_addr = '0;
        bus1.stall     = 1'b0;
        repeat (3) step();
        check_eq("reset addr3", 32'(bus3.rd_addr_bram), 0);
        check_eq("reset en3", 32'(bus3.rd_en_bram), 0);
        check_eq("reset busy3", 32'(bus3.busy), 0);
        check_eq("reset done3", 32'(bus3.done), 0);
        check_eq("reset en1", 32'(bus1.rd_en_bram), 0);
        check_eq("reset busy1", 32'(bus1.busy), 0);
        rst_n = 1'b1;
        step();

        // T1 row-major, base 0: 0..11
        for (int i = 0; i < 12; i++) exp_seq[i] = 4'(i);
        run_pass("t1", 1'b0, 4'd0, -1, -2, 0, 1'b0, 0, -1);

        // T2 column-major, base 5; the final 16 wraps to 0 in a 4-bit bank address
        exp_seq = '{4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0};
        run_pass("t2", 1'b1, 4'd5, -1, -2, 0, 1'b0, 0, -1);

        // T3 T1 with stall in cycles 4..5
        for (int i = 0; i < 12; i++) exp_seq[i] = 4'(i);
        run_pass("t3", 1'b0, 4'd0, 4, 5, 0, 1'b0, 0, -1);

        // T4 row-major, base 10: 10..15 then 0..5
        exp_seq = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        run_pass("t4", 1'b0, 4'd10, -1, -2, 0, 1'b0, 0, -1);

        // T5 reset in cycle 7 aborts with no done, then a fresh full pass
        for (int i = 0; i < 12; i++) exp_seq[i] = 4'(i);
        run_pass("t5a", 1'b0, 4'd0, -1, -2, 0, 1'b0, 7, -1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t5 idle%0d done", i), 32'(bus3.done), 0);
            check_eq($sformatf("t5 idle%0d busy", i), 32'(bus3.busy), 0);
            step();
        end
        run_pass("t5b", 1'b0, 4'd0, -1, -2, 0, 1'b0, 0, -1);

        // T6 start while busy ignored; start in the done cycle chains a second pass
        run_pass("t6a", 1'b0, 4'd0, -1, -2, 0, 1'b1, 0, 5);
        run_pass("t6b", 1'b0, 4'd0, -1, -2, 1, 1'b0, 0, -1);

        // N=1, M=4: 16 row-major addresses in a 2-bit bank, done in cycle 17
        for (int c = 0; c <= 19; c++) begin
            check_eq($sformatf("n1 c%0d en", c), 32'(bus1.rd_en_bram[0]), 32'((c >= 1) && (c <= 16)));
            if (c >= 1 && c <= 16)
                check_eq($sformatf("n1 c%0d addr", c), 32'(bus1.rd_addr_bram[0]), 32'((c - 1) % 4));
            check_eq($sformatf("n1 c%0d busy", c), 32'(bus1.busy), 32'((c >= 1) && (c <= 16)));
            check_eq($sformatf("n1 c%0d done", c), 32'(bus1.done), 32'(c == 17));
            bus1.start = (c == 0);
            step();
        end
        bus1.start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
